// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ requesters onto one APB slave.
// Optional ACCESS-phase watchdog is enabled by defining APB_TIMEOUT_EN.
module apb_rr_master #(
   parameter int NUM_REQ        = 2,
   parameter int A_WIDTH        = 8,
   parameter int D_WIDTH        = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       p_clk,
   input  logic                       p_rstn,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_write,
   input  logic [NUM_REQ*A_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*D_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic [D_WIDTH-1:0]         rsp_rdata,
   output logic                       rsp_err,
   output logic                       p_sel,
   output logic                       p_enable,
   output logic                       p_write,
   output logic [A_WIDTH-1:0]         p_addr,
   output logic [D_WIDTH-1:0]         wr_data,
   input  logic [D_WIDTH-1:0]         rd_data,
   input  logic                       p_ready,
   input  logic                       p_slverr
);

   localparam int          IDX_W = $clog2(NUM_REQ);
   localparam int unsigned NR    = NUM_REQ;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [IDX_W-1:0]     last, last_n;
   logic [NUM_REQ-1:0]   gnt_n, done_n, cand;
   logic [D_WIDTH-1:0]   rsp_rdata_n, wr_data_n;
   logic [A_WIDTH-1:0]   p_addr_n;
   logic                 rsp_err_n, p_sel_n, p_enable_n, p_write_n;
   logic                 win_vld, complete, timeout;
   logic [IDX_W-1:0]     win_idx;

   // First set bit of mask, searching from ptr+1 and wrapping.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                              input logic [IDX_W-1:0]   ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] win;
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 1; i <= NR; i++) begin
         idx = IDX_W'((32'(ptr) + i) % NR);
         if (!found && mask[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return {found, win};
   endfunction

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt, wait_cnt_n;

   assign timeout = (state == ACCESS) && !p_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_cnt_n = wait_cnt;
      if (state == SETUP)
         wait_cnt_n = '0;
      else if (state == ACCESS && !p_ready)
         wait_cnt_n = wait_cnt + 1'b1;
   end

   always_ff @(posedge p_clk) begin
      if (!p_rstn) wait_cnt <= '0;
      else         wait_cnt <= wait_cnt_n;
   end
`else
   // Watchdog compiled out; TIMEOUT_CYCLES is kept so overrides stay legal.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   assign complete = (state == ACCESS) && (p_ready || timeout);
   assign cand     = (state == ACCESS) ? (req & ~gnt) : (req & ~done);
   assign {win_vld, win_idx} = rr_pick(cand, last);

   always_comb begin
      state_n     = state;
      last_n      = last;
      gnt_n       = gnt;
      done_n      = '0;
      rsp_rdata_n = '0;
      rsp_err_n   = 1'b0;
      p_sel_n     = p_sel;
      p_enable_n  = p_enable;
      p_write_n   = p_write;
      p_addr_n    = p_addr;
      wr_data_n   = wr_data;

      case (state)
         IDLE: begin
            if (win_vld) begin
               state_n    = SETUP;
               last_n     = win_idx;
               gnt_n      = NUM_REQ'(1) << win_idx;
               p_sel_n    = 1'b1;
               p_enable_n = 1'b0;
               p_write_n  = req_write[win_idx];
               p_addr_n   = req_addr[win_idx*A_WIDTH +: A_WIDTH];
               wr_data_n  = req_wdata[win_idx*D_WIDTH +: D_WIDTH];
            end
         end
         SETUP: begin
            state_n    = ACCESS;
            p_enable_n = 1'b1;
         end
         ACCESS: begin
            if (complete) begin
               done_n      = gnt;
               // A real p_ready wins over a coincident watchdog expiry.
               rsp_rdata_n = (p_write || !p_ready) ? '0 : rd_data;
               rsp_err_n   = p_ready ? p_slverr : 1'b1;
               p_enable_n  = 1'b0;
               if (win_vld) begin
                  state_n   = SETUP;
                  last_n    = win_idx;
                  gnt_n     = NUM_REQ'(1) << win_idx;
                  p_write_n = req_write[win_idx];
                  p_addr_n  = req_addr[win_idx*A_WIDTH +: A_WIDTH];
                  wr_data_n = req_wdata[win_idx*D_WIDTH +: D_WIDTH];
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  p_sel_n = 1'b0;
               end
            end
         end
         default: begin
            state_n    = IDLE;
            gnt_n      = '0;
            p_sel_n    = 1'b0;
            p_enable_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge p_clk) begin
      if (!p_rstn) begin
         state     <= IDLE;
         last      <= IDX_W'(NUM_REQ - 1);
         gnt       <= '0;
         done      <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         p_sel     <= 1'b0;
         p_enable  <= 1'b0;
         p_write   <= 1'b0;
         p_addr    <= '0;
         wr_data   <= '0;
      end else begin
         state     <= state_n;
         last      <= last_n;
         gnt       <= gnt_n;
         done      <= done_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
         p_sel     <= p_sel_n;
         p_enable  <= p_enable_n;
         p_write   <= p_write_n;
         p_addr    <= p_addr_n;
         wr_data   <= wr_data_n;
      end
   end

endmodule
